// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and sizing helpers for the add/sub sequencer.
// Provides the FSM state enum and chunk-count / index-width functions.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int nchunk(int width, int chunk);
        return width / chunk;
    endfunction

    // Index counter needs at least one bit even for a single chunk.
    function automatic int idx_width(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_seq_adder.sv
// lpm_add_sub: combinational narrow adder/subtractor (lpm_pipeline = 0).
// Ports: dataa/datab operands, cin, add_sub (1 = add), result, cout, overflow.
module lpm_add_sub #(
    parameter int lpm_width    = 16,
    parameter int lpm_pipeline = 0
) (
    input  logic [lpm_width-1:0] dataa,
    input  logic [lpm_width-1:0] datab,
    input  logic                 cin,
    input  logic                 add_sub,
    input  logic                 clock,
    input  logic                 clken,
    input  logic                 aclr,
    output logic [lpm_width-1:0] result,
    output logic                 cout,
    output logic                 overflow
);

    logic [lpm_width-1:0] w_b;
    logic [lpm_width:0]   w_full;

    // Only the combinational form is modelled; clock pins are inert.
    logic w_unused;
    assign w_unused = &{1'b0, clock, clken, aclr, (lpm_pipeline != 0)};

    // Subtract is a + ~b + cin, i.e. a - b - !cin.
    assign w_b    = add_sub ? datab : ~datab;
    assign w_full = {1'b0, dataa} + {1'b0, w_b}
                  + {{lpm_width{1'b0}}, cin};

    assign result   = w_full[lpm_width-1:0];
    assign cout     = w_full[lpm_width];
    assign overflow = (dataa[lpm_width-1] == w_b[lpm_width-1])
                   && (result[lpm_width-1] != dataa[lpm_width-1]);

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: WIDTH-bit add/sub sequenced over one CHUNK-bit adder, LSB first.
// Ports: clock/reset, req_* (valid/ready, sub, a, b), resp_* (valid/ready,
// result, cout, overflow).
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sub,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_cout,
    output logic             resp_overflow
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IW-1:0]    r_idx;

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_unused_ovf;
    logic             w_accept;
    logic             w_last;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = req_valid && req_ready;
    assign w_last   = (r_idx == LAST);
    assign w_a      = r_opa[r_idx*CHUNK +: CHUNK];
    assign w_b      = r_opb[r_idx*CHUNK +: CHUNK];

    // add_sub is tied to add; subtraction comes from ~b and cin = 1.
    lpm_add_sub #(
        .lpm_width    (CHUNK),
        .lpm_pipeline (0)
    ) u_add (
        .dataa    (w_a),
        .datab    (w_b),
        .cin      (r_carry),
        .add_sub  (1'b1),
        .clock    (clock),
        .clken    (1'b1),
        .aclr     (1'b0),
        .result   (w_sum),
        .cout     (w_cout),
        .overflow (w_unused_ovf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_opa   <= req_a;
            r_opb   <= req_sub ? ~req_b : req_b;
            r_carry <= req_sub;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_result[r_idx*CHUNK +: CHUNK] <= w_sum;
            r_carry <= w_cout;
            // Wrap at the last chunk so idx never points past the operand.
            r_idx   <= w_last ? '0 : r_idx + IW'(1);
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= (r_opa[WIDTH-1] == r_opb[WIDTH-1])
                       && (w_sum[CHUNK-1] != r_opa[WIDTH-1]);
            end
        end
    end

    assign resp_result   = r_result;
    assign resp_cout     = r_cout;
    assign resp_overflow = r_ovf;

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: scoreboard bench for addsub_seq (64/16 and 32/32 configs).
// Directed vectors; a negedge monitor pops expected results per handshake.
module tb_addsub_seq;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_sub;
    logic [63:0] req_a, req_b;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_result;
    logic        resp_cout, resp_overflow;

    logic        s_req_valid, s_req_ready, s_req_sub;
    logic [31:0] s_req_a, s_req_b;
    logic        s_resp_valid, s_resp_ready;
    logic [31:0] s_resp_result;
    logic        s_resp_cout, s_resp_overflow;

    exp_t q64[$];
    exp_t q32[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
        .clock(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sub(req_sub), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_cout(resp_cout),
        .resp_overflow(resp_overflow)
    );

    addsub_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clock(clk), .reset(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_sub(s_req_sub), .req_a(s_req_a), .req_b(s_req_b),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
        .resp_result(s_resp_result), .resp_cout(s_resp_cout),
        .resp_overflow(s_resp_overflow)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (q64.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp64: got %h want none", resp_result);
            end else begin
                e = q64.pop_front();
                chk("result64", resp_result, e.r);
                chk("cout64", {63'd0, resp_cout}, {63'd0, e.c});
                chk("ovf64", {63'd0, resp_overflow}, {63'd0, e.o});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_resp_valid && s_resp_ready) begin
            if (q32.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp32: got %h want none", s_resp_result);
            end else begin
                e = q32.pop_front();
                chk("result32", {32'd0, s_resp_result}, e.r);
                chk("cout32", {63'd0, s_resp_cout}, {63'd0, e.c});
                chk("ovf32", {63'd0, s_resp_overflow}, {63'd0, e.o});
            end
        end
    end

    task automatic wait_ready64();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic wait_resp64(input int want_lat);
        int lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!resp_valid && lat < 50);
        chk("latency64", lat, want_lat);
    endtask

    task automatic op64(input logic sub, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] er,
                        input logic ec, input logic eo);
        exp_t e;
        e.r = er; e.c = ec; e.o = eo;
        q64.push_back(e);
        req_sub = sub; req_a = a; req_b = b; req_valid = 1'b1;
        wait_ready64();
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = 64'hDEAD_BEEF_0BAD_F00D;
        req_b = 64'h5A5A_A5A5_C3C3_3C3C;
        req_sub = ~sub;
        wait_resp64(4);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   seen;
        int   lat;
        rst = 1'b1;
        req_valid = 1'b0; req_sub = 1'b0; req_a = '0; req_b = '0;
        resp_ready = 1'b1;
        s_req_valid = 1'b0; s_req_sub = 1'b0; s_req_a = '0; s_req_b = '0;
        s_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_result", resp_result, 64'd0);
        chk("rst_cout_ovf", {62'd0, resp_cout, resp_overflow}, 64'd0);
        chk("rst_resp_valid32", {63'd0, s_resp_valid}, 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

        op64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
        op64(1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        op64(1'b1, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0);
        op64(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
        op64(1'b1, 64'h8000_0000_0000_0000, 64'd1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure with a second request waiting.
        resp_ready = 1'b0;
        e.r = 64'h0001_0000_0000_0000; e.c = 1'b0; e.o = 1'b0;
        q64.push_back(e);
        req_sub = 1'b0; req_valid = 1'b1;
        req_a = 64'h0000_FFFF_FFFF_0000; req_b = 64'h0000_0000_0001_0000;
        wait_ready64();
        @(posedge clk); #1;
        e.r = 64'h0001_1234; e.c = 1'b0; e.o = 1'b0;
        q64.push_back(e);
        req_a = 64'h1234; req_b = 64'h0001_0000;
        wait_resp64(4);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_stable", resp_result, 64'h0001_0000_0000_0000);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        chk("bp_stable_end", resp_result, 64'h0001_0000_0000_0000);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", {63'd0, req_ready}, 64'd1);
        chk("bp_idle_valid", {63'd0, resp_valid}, 64'd0);
        chk("bp_hold_result", resp_result, 64'h0001_0000_0000_0000);
        @(posedge clk); #1;
        chk("bp_accepted", {63'd0, req_ready}, 64'd0);
        req_valid = 1'b0;
        wait_resp64(4);
        @(posedge clk); #1;

        // Reset while idx = 2 discards the operation.
        req_sub = 1'b0; req_a = '1; req_b = 64'd1; req_valid = 1'b1;
        wait_ready64();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        chk("post_rst_result", resp_result, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("no_resp_after_rst", {63'd0, seen}, 64'd0);
        op64(1'b0, 64'd3, 64'd4, 64'd7, 1'b0, 1'b0);

        // Single-chunk configuration.
        e.r = 64'hFFFF_FFFE; e.c = 1'b1; e.o = 1'b0;
        q32.push_back(e);
        s_req_sub = 1'b0; s_req_a = 32'hFFFF_FFFF; s_req_b = 32'hFFFF_FFFF;
        s_req_valid = 1'b1;
        chk("ready32", {63'd0, s_req_ready}, 64'd1);
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        s_req_a = 32'h0; s_req_b = 32'h1234_5678;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!s_resp_valid && lat < 50);
        chk("latency32", lat, 1);
        @(posedge clk); #1;
        chk("idle32", {63'd0, s_resp_valid}, 64'd0);

        repeat (2) @(posedge clk);
        chk("q64_drained", q64.size(), 0);
        chk("q32_drained", q32.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
